// File: rtl/localization_pkg.sv
// ============================================================================
// localization_pkg
//   Shared phase format, array geometry and sequencing states for the
//   localization and steering datapaths.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package localization_pkg;

  localparam int PHASE_W = 16;

  typedef logic signed [PHASE_W-1:0] phase_t;

  // 3.13 radians: pi and 2*pi
  localparam phase_t                 PI     = 16'sh6488;
  localparam logic signed [16:0]     TWO_PI = 17'sh0C910;

  // Mic positions relative to the central mic at (0,0)
  localparam int MIC0_X = 0;
  localparam int MIC0_Y = 1;
  localparam int MIC1_X = -1;
  localparam int MIC1_Y = -1;
  localparam int MIC2_X = 1;
  localparam int MIC2_Y = -1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROJ  = 3'd1,
    SCALE = 3'd2,
    WRAP  = 3'd3,
    RUN   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/phase_wrap.sv
// ============================================================================
// phase_wrap
//   Single-step wrap of a 21-bit signed 3.13 phase toward [-pi, pi].
//   Revision: 1.0
// ============================================================================
`default_nettype none

module phase_wrap
  import localization_pkg::*;
(
  input  logic signed [20:0] i_val,
  output logic signed [20:0] o_val
);

  localparam logic signed [20:0] c_pi     = {{5{PI[15]}}, PI};
  localparam logic signed [20:0] c_two_pi = {{4{TWO_PI[16]}}, TWO_PI};

  // Exactly +/-pi is left untouched
  always_comb begin
    o_val = i_val;
    if (i_val > c_pi) begin
      o_val = i_val - c_two_pi;
    end else if (i_val < -c_pi) begin
      o_val = i_val + c_two_pi;
    end
  end

endmodule

`default_nettype wire

// File: rtl/steering_phase_generator.sv
// ============================================================================
// steering_phase_generator
//   Turns a direction vector into per-bin phase offsets of mic0..mic2
//   relative to the central mic, streamed one bin per transfer.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module steering_phase_generator
  import localization_pkg::*;
#(
  parameter int NUM_BINS = 512,
  parameter int BIN_W    = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [31:0]      dir_in,
  input  logic [15:0]      k_scale_in,
  input  logic             dir_valid_in,
  output logic             dir_ready_out,
  output logic [47:0]      phases_out,
  output logic [BIN_W-1:0] bin_out,
  output logic             last_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam logic signed [20:0] c_pi = {{5{PI[15]}}, PI};

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [15:0] r_x;
  logic signed [15:0] r_y;
  logic [15:0]        r_k;
  logic signed [17:0] r_p       [3];
  logic signed [20:0] r_raw     [3];
  phase_t             r_delta   [3];
  phase_t             r_acc     [3];
  logic [BIN_W-1:0]   r_bin;

  logic signed [34:0] w_prod     [3];
  logic signed [16:0] w_sum      [3];
  logic signed [20:0] w_wrap_in  [3];
  logic signed [20:0] w_wrap_out [3];
  logic [2:0]         w_in_range;
  logic               w_all_in_range;
  logic               w_xfer;
  logic               w_last;
  logic               w_unused;

  // One wrap unit per mic, shared between raw-delta reduction and accumulation
  generate
    for (genvar i = 0; i < 3; i++) begin : g_mic
      assign w_prod[i]     = 35'(r_p[i]) * 35'($signed({1'b0, r_k}));
      assign w_sum[i]      = {r_acc[i][15], r_acc[i]} + {r_delta[i][15], r_delta[i]};
      assign w_wrap_in[i]  = (r_state == RUN) ? {{4{w_sum[i][16]}}, w_sum[i]} : r_raw[i];
      assign w_in_range[i] = (r_raw[i] <= c_pi) && (r_raw[i] >= -c_pi);

      phase_wrap u_wrap (
        .i_val (w_wrap_in[i]),
        .o_val (w_wrap_out[i])
      );
    end
  endgenerate

  assign w_unused = ^{w_prod[0][34], w_prod[0][12:0],
                      w_prod[1][34], w_prod[1][12:0],
                      w_prod[2][34], w_prod[2][12:0]};

  assign w_all_in_range = &w_in_range;
  assign w_last         = (r_bin == BIN_W'(NUM_BINS - 1));
  assign w_xfer         = (r_state == RUN) && ready_in;

  assign dir_ready_out = (r_state == IDLE);
  assign valid_out     = (r_state == RUN);
  assign last_out      = (r_state == RUN) && w_last;
  assign bin_out       = r_bin;
  assign phases_out    = {r_acc[2], r_acc[1], r_acc[0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (dir_valid_in) w_state_nxt = PROJ;
      PROJ:    w_state_nxt = SCALE;
      SCALE:   w_state_nxt = WRAP;
      WRAP:    if (w_all_in_range) w_state_nxt = RUN;
      RUN:     if (w_xfer && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_bin   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_p[i]     <= '0;
        r_raw[i]   <= '0;
        r_delta[i] <= '0;
        r_acc[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (dir_valid_in) begin
            r_x <= dir_in[15:0];
            r_y <= dir_in[31:16];
            r_k <= k_scale_in;
          end
        end
        // Dot product of each mic position with (x, y)
        PROJ: begin
          r_p[0] <= 18'(r_y);
          r_p[1] <= -18'(r_x) - 18'(r_y);
          r_p[2] <= 18'(r_x) - 18'(r_y);
        end
        SCALE: begin
          for (int i = 0; i < 3; i++) begin
            r_raw[i] <= w_prod[i][33:13];
          end
        end
        WRAP: begin
          if (w_all_in_range) begin
            r_bin <= '0;
            for (int i = 0; i < 3; i++) begin
              r_delta[i] <= r_raw[i][15:0];
              r_acc[i]   <= '0;
            end
          end else begin
            for (int i = 0; i < 3; i++) begin
              r_raw[i] <= w_wrap_out[i];
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_bin <= r_bin + BIN_W'(1);
            for (int i = 0; i < 3; i++) begin
              r_acc[i] <= w_wrap_out[i][15:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_steering_phase_generator.sv
// ============================================================================
// tb_steering_phase_generator
//   Scoreboard bench for steering_phase_generator with NUM_BINS = 8.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_steering_phase_generator;

  localparam int NB = 8;
  localparam int BW = 3;

  logic          clk_in       = 1'b0;
  logic          rst_n_in     = 1'b0;
  logic [31:0]   dir_in       = '0;
  logic [15:0]   k_scale_in   = '0;
  logic          dir_valid_in = 1'b0;
  logic          ready_in     = 1'b1;
  logic          dir_ready_out;
  logic [47:0]   phases_out;
  logic [BW-1:0] bin_out;
  logic          last_out;
  logic          valid_out;

  typedef struct {
    logic [47:0] ph;
    int          bin;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          n_xfer  = 0;
  bit          rand_ready = 1'b0;
  logic [47:0] obs_ph [NB];

  steering_phase_generator #(.NUM_BINS(NB), .BIN_W(BW)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .dir_in        (dir_in),
    .k_scale_in    (k_scale_in),
    .dir_valid_in  (dir_valid_in),
    .dir_ready_out (dir_ready_out),
    .phases_out    (phases_out),
    .bin_out       (bin_out),
    .last_out      (last_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rand_ready) begin
      #1 ready_in = ($urandom_range(0, 2) != 0);
    end
  end

  // Every valid cycle must present the head of the scoreboard; a transfer pops it
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got valid bin=%0d, want no output", bin_out);
      end else begin
        if (phases_out !== exp_q[0].ph || int'(bin_out) != exp_q[0].bin ||
            last_out !== exp_q[0].last) begin
          errors++;
          $display("FAIL stream: got ph=%h bin=%0d last=%0b, want ph=%h bin=%0d last=%0b",
                   phases_out, bin_out, last_out, exp_q[0].ph, exp_q[0].bin, exp_q[0].last);
        end
        if (ready_in) begin
          obs_ph[bin_out] = phases_out;
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  function automatic int wrapm(input int v);
    if (v > 25736) return v - 51472;
    if (v < -25736) return v + 51472;
    return v;
  endfunction

  task automatic push_dir(input int x, input int y, input int k, output int iters);
    int     p [3];
    int     d [3];
    int     acc [3];
    int     r;
    int     n;
    longint pr;
    exp_t   e;
    p[0] = y;
    p[1] = -x - y;
    p[2] = x - y;
    iters = 0;
    for (int i = 0; i < 3; i++) begin
      pr = longint'(p[i]) * longint'(k);
      r  = int'(pr >>> 13);
      n  = 0;
      while (r > 25736 || r < -25736) begin
        r = wrapm(r);
        n++;
      end
      d[i]   = r;
      acc[i] = 0;
      if (n > iters) iters = n;
    end
    for (int b = 0; b < NB; b++) begin
      e.ph   = {16'(acc[2]), 16'(acc[1]), 16'(acc[0])};
      e.bin  = b;
      e.last = (b == NB - 1);
      exp_q.push_back(e);
      for (int i = 0; i < 3; i++) acc[i] = wrapm(acc[i] + d[i]);
    end
  endtask

  task automatic send_dir(input int x, input int y, input int k, output int lat, output int iters);
    int n;
    push_dir(x, y, k, iters);
    @(posedge clk_in); #1;
    dir_in       = {16'(y), 16'(x)};
    k_scale_in   = 16'(k);
    dir_valid_in = 1'b1;
    n = 0;
    while (!dir_ready_out && n < 2000) begin
      @(posedge clk_in); #1;
      n++;
    end
    @(posedge clk_in); #1;
    dir_valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !dir_ready_out) && n < 500) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_obs();
    for (int b = 0; b < NB; b++) obs_ph[b] = '1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (valid_out !== 1'b0 || dir_ready_out !== 1'b1 || phases_out !== 48'h0 ||
        bin_out !== '0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b rdy=%0b ph=%h bin=%0d last=%0b, want 0 1 0 0 0",
               valid_out, dir_ready_out, phases_out, bin_out, last_out);
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int lat, it, n;
    send_dir(0, 1024, 4096, lat, it);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(valid_out && bin_out == 3'd5) && n < 100);
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (n >= 100 || valid_out !== 1'b0 || dir_ready_out !== 1'b1 || bin_out !== '0 ||
        phases_out !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid_run: got v=%0b rdy=%0b bin=%0d ph=%h, want 0 1 0 0",
               valid_out, dir_ready_out, bin_out, phases_out);
    end
    exp_q.delete();
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    send_dir(0, 1024, 4096, lat, it);
    wait_idle();
  endtask

  task automatic test_basic_ramp();
    int lat, it;
    clear_obs();
    send_dir(0, 1024, 4096, lat, it);
    wait_idle();
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL ramp_latency: got %0d, want 3", lat);
    end
    checks++;
    if (obs_ph[0] !== 48'h0) begin
      errors++;
      $display("FAIL ramp_bin0: got %h, want 0", obs_ph[0]);
    end
    checks++;
    if (obs_ph[1] !== {16'hFE00, 16'hFE00, 16'h0200}) begin
      errors++;
      $display("FAIL ramp_bin1: got %h, want fe00fe000200", obs_ph[1]);
    end
    checks++;
    if (obs_ph[2] !== {16'hFC00, 16'hFC00, 16'h0400}) begin
      errors++;
      $display("FAIL ramp_bin2: got %h, want fc00fc000400", obs_ph[2]);
    end
  endtask

  task automatic test_single_wrap();
    int lat, it;
    clear_obs();
    send_dir(0, 4096, 65535, lat, it);
    wait_idle();
    checks++;
    if (lat != 3 + it) begin
      errors++;
      $display("FAIL single_latency: got %0d, want %0d", lat, 3 + it);
    end
    checks++;
    if (obs_ph[1] !== {16'h4910, 16'h4910, 16'hB6EF}) begin
      errors++;
      $display("FAIL single_delta: got %h, want 49104910b6ef", obs_ph[1]);
    end
    checks++;
    if (obs_ph[2] !== {16'hC910, 16'hC910, 16'h36EE}) begin
      errors++;
      $display("FAIL single_bin2: got %h, want c910c91036ee", obs_ph[2]);
    end
  endtask

  task automatic test_multi_wrap();
    int lat, it;
    clear_obs();
    send_dir(-32768, -32768, 65535, lat, it);
    wait_idle();
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL multi_latency: got %0d, want 13", lat);
    end
    checks++;
    if (obs_ph[1] !== {16'h0000, 16'h2558, 16'hED54}) begin
      errors++;
      $display("FAIL multi_delta: got %h, want 00002558ed54", obs_ph[1]);
    end
  endtask

  task automatic test_boundary();
    int lat, it;
    clear_obs();
    send_dir(0, 12868, 16384, lat, it);
    wait_idle();
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL boundary_latency: got %0d, want 3", lat);
    end
    checks++;
    if (obs_ph[1] !== {16'h9B78, 16'h9B78, 16'h6488}) begin
      errors++;
      $display("FAIL boundary_pi: got %h, want 9b789b786488", obs_ph[1]);
    end
    checks++;
    if (obs_ph[2] !== 48'h0) begin
      errors++;
      $display("FAIL boundary_twopi: got %h, want 0", obs_ph[2]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, it, start, n;
    start = n_xfer;
    rand_ready = 1'b1;
    send_dir(1000, -700, 30000, lat, it);
    dir_in       = {16'(2000), 16'(-500)};
    k_scale_in   = 16'(20000);
    dir_valid_in = 1'b1;
    n = 0;
    while (!dir_ready_out && n < 500) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (n_xfer - start != NB) begin
      errors++;
      $display("FAIL early_accept: got %0d transfers before accept, want %0d", n_xfer - start, NB);
    end
    push_dir(-500, 2000, 20000, it);
    @(posedge clk_in); #1;
    dir_valid_in = 1'b0;
    wait_idle();
    checks++;
    if (n_xfer - start != 2 * NB) begin
      errors++;
      $display("FAIL xfer_count: got %0d, want %0d", n_xfer - start, 2 * NB);
    end
    rand_ready = 1'b0;
    @(posedge clk_in); #2;
    ready_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic_ramp();
    test_single_wrap();
    test_multi_wrap();
    test_boundary();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
